// File: rtl/ddr3_app_responder.sv
// Block-RAM stand-in for a DDR3 controller user (app_*) interface.
// Models calibration delay, periodic refresh back-pressure, write command/data pairing and fixed read latency.
module ddr3_app_responder #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int DEPTH_LOG2   = 17,
  parameter int RD_LAT       = 6,
  parameter int CALIB_CYCLES = 64,
  parameter int REF_PERIOD   = 1024,
  parameter int REF_LEN      = 8
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  input  logic [ADDR_W-1:0]   app_addr,
  input  logic [2:0]          app_cmd,
  input  logic                app_en,
  output logic                app_rdy,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  output logic                init_calib_complete
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_CALIB   = 2'd0,
    ST_RUN     = 2'd1,
    ST_REFRESH = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [31:0]                     calib_cnt_q, calib_cnt_d;
  logic [31:0]                     ref_cnt_q, ref_cnt_d;
  logic [31:0]                     ref_len_q, ref_len_d;
  logic                            calib_done_q, calib_done_d;
  logic                            app_rdy_q, app_rdy_d;
  logic                            wdf_rdy_q, wdf_rdy_d;
  logic                            wcmd_full_q, wcmd_full_d;
  logic [DEPTH_LOG2-1:0]           wcmd_idx_q, wcmd_idx_d;
  logic                            wdat_full_q, wdat_full_d;
  logic [DATA_W-1:0]               wdat_q, wdat_d;
  logic [BE_W-1:0]                 wmask_q, wmask_d;
  logic [RD_LAT-1:0]               rd_vld_q, rd_vld_d;
  logic [RD_LAT-2:0][DATA_W-1:0]   rd_dat_q, rd_dat_d;
  logic [DATA_W-1:0]               rd_data_q, rd_data_d;

  logic                  cmd_acc_s, wr_cmd_s, rd_cmd_s, data_acc_s, commit_s;
  logic [DEPTH_LOG2-1:0] addr_idx_s, commit_idx_s;
  logic [DATA_W-1:0]     commit_data_s, rd_word_s;
  logic [BE_W-1:0]       commit_mask_s;
  logic                  unused_bits;

  logic [DATA_W-1:0] mem [DEPTH];

  assign unused_bits = ^{app_addr[2:0], app_addr[ADDR_W-1:DEPTH_LOG2+3], app_wdf_end};

  // Handshakes and write pairing; a write commits once both slots are (or become) full.
  always_comb begin
    addr_idx_s    = app_addr[3 +: DEPTH_LOG2];
    cmd_acc_s     = app_en & app_rdy_q;
    wr_cmd_s      = cmd_acc_s & (app_cmd == 3'b000);
    rd_cmd_s      = cmd_acc_s & (app_cmd == 3'b001);
    data_acc_s    = app_wdf_wren & wdf_rdy_q;
    commit_s      = (wcmd_full_q | wr_cmd_s) & (wdat_full_q | data_acc_s) & ~ui_clk_sync_rst;
    commit_idx_s  = wcmd_full_q ? wcmd_idx_q : addr_idx_s;
    commit_data_s = wdat_full_q ? wdat_q : app_wdf_data;
    commit_mask_s = wdat_full_q ? wmask_q : app_wdf_mask;
    wcmd_full_d   = (wcmd_full_q | wr_cmd_s) & ~commit_s;
    wcmd_idx_d    = wr_cmd_s ? addr_idx_s : wcmd_idx_q;
    wdat_full_d   = (wdat_full_q | data_acc_s) & ~commit_s;
    wdat_d        = data_acc_s ? app_wdf_data : wdat_q;
    wmask_d       = data_acc_s ? app_wdf_mask : wmask_q;
  end

  // Calibration / run / refresh sequencing and the registered ready outputs.
  always_comb begin
    state_d      = state_q;
    calib_cnt_d  = calib_cnt_q;
    ref_cnt_d    = ref_cnt_q;
    ref_len_d    = ref_len_q;
    calib_done_d = calib_done_q;
    case (state_q)
      ST_CALIB: begin
        if (calib_cnt_q == 32'(CALIB_CYCLES - 1)) begin
          state_d      = ST_RUN;
          calib_done_d = 1'b1;
        end else begin
          calib_cnt_d = calib_cnt_q + 32'd1;
        end
      end
      ST_RUN: begin
        if ((REF_PERIOD != 0) && (ref_cnt_q == 32'(REF_PERIOD - 1))) begin
          state_d   = ST_REFRESH;
          ref_len_d = 32'd0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_REFRESH: begin
        if (ref_len_q == 32'(REF_LEN - 1)) begin
          state_d = ST_RUN;
        end else begin
          ref_len_d = ref_len_q + 32'd1;
        end
      end
      default: state_d = ST_CALIB;
    endcase
    if (state_q == ST_RUN || state_q == ST_REFRESH) begin
      ref_cnt_d = (ref_cnt_q == 32'(REF_PERIOD - 1)) ? 32'd0 : ref_cnt_q + 32'd1;
    end else begin
      ref_cnt_d = ref_cnt_q;
    end
    app_rdy_d = (state_d == ST_RUN) & ~wcmd_full_d;
    wdf_rdy_d = ((state_d == ST_RUN) | (state_d == ST_REFRESH)) & ~wdat_full_d;
  end

  // Read pipeline: RAM word captured on acceptance, shifted RD_LAT-1 stages, then held at the output.
  always_comb begin
    rd_word_s = mem[addr_idx_s];
    rd_vld_d  = {rd_vld_q[RD_LAT-2:0], rd_cmd_s};
    rd_dat_d  = rd_dat_q;
    rd_dat_d[0] = rd_cmd_s ? rd_word_s : rd_dat_q[0];
    for (int k = 1; k < RD_LAT - 1; k++) begin
      rd_dat_d[k] = rd_dat_q[k-1];
    end
    rd_data_d = rd_vld_q[RD_LAT-2] ? rd_dat_q[RD_LAT-2] : rd_data_q;
  end

  // State registers.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q      <= ST_CALIB;
      calib_cnt_q  <= 32'd0;
      ref_cnt_q    <= 32'd0;
      ref_len_q    <= 32'd0;
      calib_done_q <= 1'b0;
      app_rdy_q    <= 1'b0;
      wdf_rdy_q    <= 1'b0;
      wcmd_full_q  <= 1'b0;
      wcmd_idx_q   <= '0;
      wdat_full_q  <= 1'b0;
      wdat_q       <= '0;
      wmask_q      <= '0;
      rd_vld_q     <= '0;
      rd_dat_q     <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      calib_cnt_q  <= calib_cnt_d;
      ref_cnt_q    <= ref_cnt_d;
      ref_len_q    <= ref_len_d;
      calib_done_q <= calib_done_d;
      app_rdy_q    <= app_rdy_d;
      wdf_rdy_q    <= wdf_rdy_d;
      wcmd_full_q  <= wcmd_full_d;
      wcmd_idx_q   <= wcmd_idx_d;
      wdat_full_q  <= wdat_full_d;
      wdat_q       <= wdat_d;
      wmask_q      <= wmask_d;
      rd_vld_q     <= rd_vld_d;
      rd_dat_q     <= rd_dat_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // RAM byte-masked write; contents survive reset.
  always_ff @(posedge ui_clk) begin
    if (commit_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (!commit_mask_s[b]) begin
          mem[commit_idx_s][8*b +: 8] <= commit_data_s[8*b +: 8];
        end
      end
    end
  end

  assign app_rdy             = app_rdy_q;
  assign app_wdf_rdy         = wdf_rdy_q;
  assign app_rd_data         = rd_data_q;
  assign app_rd_data_valid   = rd_vld_q[RD_LAT-1];
  assign app_rd_data_end     = rd_vld_q[RD_LAT-1];
  assign init_calib_complete = calib_done_q;

endmodule
